// File: rtl/global_dependency_tracker_if.sv
// Batch-registration, retire and conflict-query bus between the conflict-detection
// pipeline (master) and the global dependency tracker (slave).
interface global_dependency_tracker_if #(
  parameter int MAX_DEPENDENCIES     = 256,
  parameter int MAX_INFLIGHT_BATCHES = 4,
  parameter int SLOT_W               = $clog2(MAX_INFLIGHT_BATCHES)
);
  logic                            reg_valid;
  logic                            reg_ready;
  logic [MAX_DEPENDENCIES-1:0]     reg_read_deps;
  logic [MAX_DEPENDENCIES-1:0]     reg_write_deps;
  logic [63:0]                     reg_owner_id;
  logic [SLOT_W-1:0]               reg_slot;
  logic                            rel_valid;
  logic [SLOT_W-1:0]               rel_slot;
  logic                            q_valid;
  logic [MAX_DEPENDENCIES-1:0]     q_read_deps;
  logic [MAX_DEPENDENCIES-1:0]     q_write_deps;
  logic                            q_resp_valid;
  logic                            q_conflict;
  logic [MAX_INFLIGHT_BATCHES-1:0] q_conflict_mask;
  logic [2:0]                      q_conflict_type;
  logic [63:0]                     slot_owner_id;
  logic [MAX_DEPENDENCIES-1:0]     active_read_union;
  logic [MAX_DEPENDENCIES-1:0]     active_write_union;
  logic [SLOT_W:0]                 inflight_count;

  modport master (
    output reg_valid, reg_read_deps, reg_write_deps, reg_owner_id,
    output rel_valid, rel_slot, q_valid, q_read_deps, q_write_deps,
    input  reg_ready, reg_slot, q_resp_valid, q_conflict, q_conflict_mask,
    input  q_conflict_type, slot_owner_id, active_read_union, active_write_union,
    input  inflight_count
  );

  modport slave (
    input  reg_valid, reg_read_deps, reg_write_deps, reg_owner_id,
    input  rel_valid, rel_slot, q_valid, q_read_deps, q_write_deps,
    output reg_ready, reg_slot, q_resp_valid, q_conflict, q_conflict_mask,
    output q_conflict_type, slot_owner_id, active_read_union, active_write_union,
    output inflight_count
  );
endinterface

// File: rtl/global_dependency_tracker.sv
// Slot table of in-flight batch read/write dependency unions with RAW/WAW/WAR queries.
// Optional macro GDT_STATS_EN adds registered/released/release-error counters.
module global_dependency_tracker #(
  parameter int MAX_DEPENDENCIES     = 256,
  parameter int MAX_INFLIGHT_BATCHES = 4,
  parameter int SLOT_W               = $clog2(MAX_INFLIGHT_BATCHES)
) (
  input  logic                       clk,
  input  logic                       rst,
  global_dependency_tracker_if.slave bus
`ifdef GDT_STATS_EN
  ,
  output logic [31:0]                registered_count,
  output logic [31:0]                released_count,
  output logic [31:0]                release_errors
`endif
);
  localparam int N = MAX_INFLIGHT_BATCHES;
  localparam int D = MAX_DEPENDENCIES;

  logic [N-1:0]      slot_valid;
  logic [N-1:0]      valid_next;
  logic [D-1:0]      slot_read  [N];
  logic [D-1:0]      slot_write [N];
  logic [63:0]       slot_owner [N];
  logic              any_free;
  logic [SLOT_W-1:0] free_slot;
  logic              grant;
  logic              rel_hit;
  logic [D-1:0]      read_union_next;
  logic [D-1:0]      write_union_next;
  logic [SLOT_W:0]   count_next;
  logic [N-1:0]      raw_hit;
  logic [N-1:0]      waw_hit;
  logic [N-1:0]      war_hit;

  // Descending scan so the lowest free index wins.
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        any_free  = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
  end

  assign bus.reg_ready     = any_free;
  assign bus.reg_slot      = free_slot;
  assign bus.slot_owner_id = slot_owner[bus.rel_slot];
  assign grant             = bus.reg_valid && any_free;
  assign rel_hit           = bus.rel_valid && slot_valid[bus.rel_slot];

  // Post-edge view of the table, so unions and count are registered already up to date.
  always_comb begin
    valid_next       = slot_valid;
    read_union_next  = '0;
    write_union_next = '0;
    count_next       = '0;
    if (rel_hit) valid_next[bus.rel_slot] = 1'b0;
    if (grant)   valid_next[free_slot]    = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (valid_next[i]) begin
        count_next = count_next + (SLOT_W + 1)'(1);
        if (grant && free_slot == SLOT_W'(i)) begin
          read_union_next  = read_union_next  | bus.reg_read_deps;
          write_union_next = write_union_next | bus.reg_write_deps;
        end else begin
          read_union_next  = read_union_next  | slot_read[i];
          write_union_next = write_union_next | slot_write[i];
        end
      end
    end
  end

  always_comb begin
    raw_hit = '0;
    waw_hit = '0;
    war_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (slot_valid[i]) begin
        raw_hit[i] = |(bus.q_read_deps  & slot_write[i]);
        waw_hit[i] = |(bus.q_write_deps & slot_write[i]);
        war_hit[i] = |(bus.q_write_deps & slot_read[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < N; i++) begin
        slot_read[i]  <= '0;
        slot_write[i] <= '0;
        slot_owner[i] <= '0;
      end
    end else begin
      slot_valid <= valid_next;
      if (grant) begin
        slot_read[free_slot]  <= bus.reg_read_deps;
        slot_write[free_slot] <= bus.reg_write_deps;
        slot_owner[free_slot] <= bus.reg_owner_id;
      end
    end
  end

  // Query results hold their last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.q_resp_valid       <= 1'b0;
      bus.q_conflict         <= 1'b0;
      bus.q_conflict_mask    <= '0;
      bus.q_conflict_type    <= '0;
      bus.active_read_union  <= '0;
      bus.active_write_union <= '0;
      bus.inflight_count     <= '0;
    end else begin
      bus.q_resp_valid       <= bus.q_valid;
      bus.active_read_union  <= read_union_next;
      bus.active_write_union <= write_union_next;
      bus.inflight_count     <= count_next;
      if (bus.q_valid) begin
        bus.q_conflict      <= |(raw_hit | waw_hit | war_hit);
        bus.q_conflict_mask <= raw_hit | waw_hit | war_hit;
        bus.q_conflict_type <= {|war_hit, |waw_hit, |raw_hit};
      end
    end
  end

`ifdef GDT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      registered_count <= '0;
      released_count   <= '0;
      release_errors   <= '0;
    end else begin
      if (grant)                     registered_count <= registered_count + 32'd1;
      if (rel_hit)                   released_count   <= released_count + 32'd1;
      if (bus.rel_valid && !rel_hit) release_errors   <= release_errors + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_global_dependency_tracker.sv
// Randomized and directed bench for global_dependency_tracker against a slot-table model
// (8-bit dependency vectors, 4 slots).
module tb_global_dependency_tracker;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;

  global_dependency_tracker_if #(.MAX_DEPENDENCIES(D), .MAX_INFLIGHT_BATCHES(N), .SLOT_W(SW)) bus ();

`ifdef GDT_STATS_EN
  logic [31:0] registered_count;
  logic [31:0] released_count;
  logic [31:0] release_errors;
`endif

  global_dependency_tracker #(.MAX_DEPENDENCIES(D), .MAX_INFLIGHT_BATCHES(N), .SLOT_W(SW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave)
`ifdef GDT_STATS_EN
    ,
    .registered_count (registered_count),
    .released_count   (released_count),
    .release_errors   (release_errors)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference table: what is in flight, as a plain array of batches.
  bit          m_valid [N];
  logic [D-1:0] m_read [N];
  logic [D-1:0] m_write[N];
  logic [63:0] m_owner [N];
  bit          e_resp;
  bit          e_conflict;
  logic [N-1:0] e_mask;
  logic [2:0]  e_type;
  logic [D-1:0] e_runion;
  logic [D-1:0] e_wunion;
  int          e_count;
  int unsigned m_registered;
  int unsigned m_released;
  int unsigned m_rel_errors;
  int          lf;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lowestFree();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  // Every negedge: check DUT against the model, then advance the model by the upcoming edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0; m_read[i] = '0; m_write[i] = '0; m_owner[i] = '0;
      end
      e_resp = 0; e_conflict = 0; e_mask = '0; e_type = '0;
      e_runion = '0; e_wunion = '0; e_count = 0;
      m_registered = 0; m_released = 0; m_rel_errors = 0;
    end
    lf = lowestFree();
    checkOutput("reg_ready", 64'(bus.reg_ready), 64'(lf >= 0));
    if (lf >= 0) checkOutput("reg_slot", 64'(bus.reg_slot), 64'(lf));
    checkOutput("slot_owner_id", bus.slot_owner_id, m_owner[bus.rel_slot]);
    checkOutput("q_resp_valid", 64'(bus.q_resp_valid), 64'(e_resp));
    checkOutput("q_conflict", 64'(bus.q_conflict), 64'(e_conflict));
    checkOutput("q_conflict_mask", 64'(bus.q_conflict_mask), 64'(e_mask));
    checkOutput("q_conflict_type", 64'(bus.q_conflict_type), 64'(e_type));
    checkOutput("active_read_union", 64'(bus.active_read_union), 64'(e_runion));
    checkOutput("active_write_union", 64'(bus.active_write_union), 64'(e_wunion));
    checkOutput("inflight_count", 64'(bus.inflight_count), 64'(e_count));
`ifdef GDT_STATS_EN
    checkOutput("registered_count", 64'(registered_count), 64'(m_registered));
    checkOutput("released_count", 64'(released_count), 64'(m_released));
    checkOutput("release_errors", 64'(release_errors), 64'(m_rel_errors));
`endif
    if (!rst) begin
      if (bus.q_valid) begin
        e_mask = '0; e_type = '0;
        for (int i = 0; i < N; i++) begin
          if (m_valid[i]) begin
            bit raw, waw, war;
            raw = (bus.q_read_deps  & m_write[i]) != 0;
            waw = (bus.q_write_deps & m_write[i]) != 0;
            war = (bus.q_write_deps & m_read[i])  != 0;
            e_mask[i] = raw | waw | war;
            e_type = e_type | {war, waw, raw};
          end
        end
        e_conflict = (e_mask != 0);
        e_resp = 1;
      end else begin
        e_resp = 0;
      end
      if (bus.rel_valid) begin
        if (m_valid[bus.rel_slot]) begin
          m_valid[bus.rel_slot] = 1'b0;
          m_released++;
        end else begin
          m_rel_errors++;
        end
      end
      if (bus.reg_valid && lf >= 0) begin
        m_valid[lf] = 1'b1;
        m_read[lf]  = bus.reg_read_deps;
        m_write[lf] = bus.reg_write_deps;
        m_owner[lf] = bus.reg_owner_id;
        m_registered++;
      end
      e_runion = '0; e_wunion = '0; e_count = 0;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i]) begin
          e_runion = e_runion | m_read[i];
          e_wunion = e_wunion | m_write[i];
          e_count++;
        end
      end
    end
  end

  // Drive one cycle of inputs, returning just after the edge that samples them.
  task automatic applyStimulus(input logic r, input logic rv, input logic [D-1:0] rr,
                               input logic [D-1:0] rw, input logic [63:0] own,
                               input logic lv, input logic [SW-1:0] ls,
                               input logic qv, input logic [D-1:0] qr, input logic [D-1:0] qw);
    rst                = r;
    bus.reg_valid      = rv;
    bus.reg_read_deps  = rr;
    bus.reg_write_deps = rw;
    bus.reg_owner_id   = own;
    bus.rel_valid      = lv;
    bus.rel_slot       = ls;
    bus.q_valid        = qv;
    bus.q_read_deps    = qr;
    bus.q_write_deps   = qw;
    @(posedge clk);
    #1;
  endtask

  task automatic doReg(input logic [D-1:0] rr, input logic [D-1:0] rw, input logic [63:0] own);
    applyStimulus(0, 1, rr, rw, own, 0, 0, 0, '0, '0);
  endtask

  task automatic doRel(input logic [SW-1:0] s);
    applyStimulus(0, 0, '0, '0, '0, 1, s, 0, '0, '0);
  endtask

  task automatic doQuery(input logic [D-1:0] qr, input logic [D-1:0] qw);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, 1, qr, qw);
  endtask

  initial begin
    rst = 1'b1;
    bus.reg_valid = 0; bus.reg_read_deps = '0; bus.reg_write_deps = '0; bus.reg_owner_id = '0;
    bus.rel_valid = 0; bus.rel_slot = '0; bus.q_valid = 0; bus.q_read_deps = '0; bus.q_write_deps = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill the table: slot0 R=10 W=01, slots1..3 W=02,04,08.
    for (int i = 0; i < N; i++) begin
      checkOutput("fill_reg_slot", 64'(bus.reg_slot), 64'(i));
      doReg((i == 0) ? 8'h10 : 8'h00, 8'(1 << i), 64'hA0 + 64'(i));
    end
    checkOutput("full_reg_ready", 64'(bus.reg_ready), 64'd0);
    checkOutput("full_wunion", 64'(bus.active_write_union), 64'h0F);
    checkOutput("full_runion", 64'(bus.active_read_union), 64'h10);
    checkOutput("full_count", 64'(bus.inflight_count), 64'd4);
    doReg(8'h00, 8'h80, 64'hEE);
    checkOutput("stall_count", 64'(bus.inflight_count), 64'd4);
    checkOutput("stall_wunion", 64'(bus.active_write_union), 64'h0F);

    doQuery(8'h20, 8'h00);
    checkOutput("q_none_resp", 64'(bus.q_resp_valid), 64'd1);
    checkOutput("q_none_conflict", 64'(bus.q_conflict), 64'd0);
    doQuery(8'h01, 8'h00);
    checkOutput("q_raw_conflict", 64'(bus.q_conflict), 64'd1);
    checkOutput("q_raw_mask", 64'(bus.q_conflict_mask), 64'h1);
    checkOutput("q_raw_type", 64'(bus.q_conflict_type), 64'h1);
    doQuery(8'h00, 8'h10);
    checkOutput("q_war_type", 64'(bus.q_conflict_type), 64'h4);
    checkOutput("q_war_mask", 64'(bus.q_conflict_mask), 64'h1);
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd2, 0, '0, '0);
    checkOutput("q_idle_resp", 64'(bus.q_resp_valid), 64'd0);
    checkOutput("q_hold_type", 64'(bus.q_conflict_type), 64'h4);
    checkOutput("owner_slot2", bus.slot_owner_id, 64'hA2);

    // Release slot 2 while full with a registration pending: no grant this cycle.
    checkOutput("simul_ready_before", 64'(bus.reg_ready), 64'd0);
    applyStimulus(0, 1, 8'h00, 8'h40, 64'hB2, 1, 2'd2, 0, '0, '0);
    checkOutput("simul_count_mid", 64'(bus.inflight_count), 64'd3);
    checkOutput("simul_reg_slot", 64'(bus.reg_slot), 64'd2);
    doReg(8'h00, 8'h40, 64'hB2);
    checkOutput("simul_count_after", 64'(bus.inflight_count), 64'd4);
    checkOutput("simul_wunion", 64'(bus.active_write_union), 64'h4B);

    // Register and release together when not full: net count change zero.
    doRel(2'd1);
    checkOutput("net_count_before", 64'(bus.inflight_count), 64'd3);
    applyStimulus(0, 1, 8'h00, 8'h20, 64'hC1, 1, 2'd0, 0, '0, '0);
    checkOutput("net_count_after", 64'(bus.inflight_count), 64'd3);
    checkOutput("net_reg_slot", 64'(bus.reg_slot), 64'd0);
    checkOutput("net_wunion", 64'(bus.active_write_union), 64'h68);
    doReg(8'h00, 8'h01, 64'hC0);

    doRel(2'd1);
    doRel(2'd3);
    checkOutput("lowest_first", 64'(bus.reg_slot), 64'd1);
    doReg(8'h00, 8'h02, 64'hD1);
    checkOutput("lowest_second", 64'(bus.reg_slot), 64'd3);
    doReg(8'h00, 8'h04, 64'hD3);
    checkOutput("lowest_count", 64'(bus.inflight_count), 64'd4);

    doRel(2'd0);
    checkOutput("rel_count", 64'(bus.inflight_count), 64'd3);
    doRel(2'd0);
    checkOutput("badrel_count", 64'(bus.inflight_count), 64'd3);
    checkOutput("badrel_wunion", 64'(bus.active_write_union), 64'h46);
`ifdef GDT_STATS_EN
    checkOutput("badrel_errors", 64'(release_errors), 64'd1);
`endif

    // Reset mid-stream right after a conflicting query.
    doQuery(8'h02, 8'h00);
    checkOutput("pre_reset_resp", 64'(bus.q_resp_valid), 64'd1);
    applyStimulus(1, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    checkOutput("reset_ready", 64'(bus.reg_ready), 64'd1);
    checkOutput("reset_count", 64'(bus.inflight_count), 64'd0);
    checkOutput("reset_runion", 64'(bus.active_read_union), 64'h00);
    checkOutput("reset_wunion", 64'(bus.active_write_union), 64'h00);
    checkOutput("reset_resp", 64'(bus.q_resp_valid), 64'd0);
    checkOutput("reset_conflict", 64'(bus.q_conflict), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    1'($urandom_range(0, 1)),
                    D'($urandom & $urandom), D'($urandom & $urandom & $urandom),
                    {$urandom, $urandom},
                    ($urandom_range(0, 2) == 0), SW'($urandom_range(0, N - 1)),
                    1'($urandom_range(0, 1)),
                    D'($urandom & $urandom & $urandom), D'($urandom & $urandom & $urandom));
    end
    applyStimulus(0, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
